// File: rtl/uart_lb_sequencer_pkg.sv
// Shared definitions for the UART local-bus sequencer: FSM state encoding,
// UART register addresses, status bit positions and a saturating increment.
package uart_lb_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STAT = 3'd1,
        S_DEC  = 3'd2,
        S_RD   = 3'd3,
        S_WR   = 3'd4
    } lb_state_t;

    localparam logic UART_ADR_STAT = 1'b1;
    localparam logic UART_ADR_DATA = 1'b0;

    localparam int ST_TXRDY = 0;
    localparam int ST_RXRDY = 1;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_lb_sequencer_fifo.sv
// uart_lb_fifo: synchronous first-word-fall-through FIFO.
// Push on full and pop on empty are dropped; push and pop in the same cycle
// are otherwise both honoured. DEPTH must be a power of 2 (>= 2) so the
// pointers wrap naturally.
module uart_lb_fifo
    import uart_lb_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents after reset are don't-care since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/uart_lb_sequencer.sv
// uart_lb_sequencer: autonomous master for the UART local bus. Polls the
// UART status register, drains received bytes into an RX FIFO and feeds
// bytes from a TX FIFO to the UART, so the host side sees only FIFO
// handshakes.
// Optional feature: define UART_OVR_CNT_EN to count polls that found RXRDY
// set while the RX FIFO was full (ovr_cnt, saturating). Otherwise ovr_cnt=0.
//
// state | meaning
// IDLE  | wait POLL_DIV cycles between status polls
// STAT  | status read cycle (cs/oe, adrs=status), capture into st_q
// DEC   | pick RD, WR or back to IDLE; rr breaks ties
// RD    | data read cycle, byte pushed into RX FIFO, then re-poll
// WR    | data write cycle from TX FIFO head, TX FIFO popped, then re-poll
module uart_lb_sequencer
    import uart_lb_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_DIV   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_wr,
    input  logic [7:0] tx_din,
    output logic       tx_full,
    input  logic       rx_rd,
    output logic [7:0] rx_dout,
    output logic       rx_empty,
    output logic       u_cs,
    output logic       u_we,
    output logic       u_oe,
    output logic       u_adrs,
    output logic [7:0] u_wdata,
    input  logic [7:0] u_rdata,
    output logic [7:0] ovr_cnt
);

    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

    lb_state_t     r_state;
    logic [PW-1:0] r_poll_cnt;
    logic          r_rr;
    logic [1:0]    r_st_q;
    logic          r_cs;
    logic          r_we;
    logic          r_oe;
    logic          r_adrs;
    logic [7:0]    r_wdata;

    logic [7:0]    w_tx_head;
    logic          w_tx_empty;
    logic          w_rx_full;
    logic          w_tx_pop;
    logic          w_rx_push;
    logic          w_rx_go;
    logic          w_tx_go;
    logic          w_rd_sel;
    logic          w_wr_sel;

    // The data cycle itself moves the byte: RD writes the bus data straight
    // into the RX FIFO on the edge that closes the read, WR pops the byte
    // whose value was latched into u_wdata on entry.
    assign w_rx_push = (r_state == S_RD);
    assign w_tx_pop  = (r_state == S_WR);

    uart_lb_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (tx_wr),
        .i_din   (tx_din),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_full  (tx_full),
        .o_empty (w_tx_empty)
    );

    uart_lb_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_din   (u_rdata),
        .i_pop   (rx_rd),
        .o_dout  (rx_dout),
        .o_full  (w_rx_full),
        .o_empty (rx_empty)
    );

    assign w_rx_go  = r_st_q[ST_RXRDY] & ~w_rx_full;
    assign w_tx_go  = r_st_q[ST_TXRDY] & ~w_tx_empty;
    assign w_rd_sel = w_rx_go & (~w_tx_go | ~r_rr);
    assign w_wr_sel = w_tx_go & (~w_rx_go |  r_rr);

    // Sequencer FSM; bus strobes are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_poll_cnt <= '0;
            r_rr       <= 1'b0;
            r_st_q     <= '0;
            r_cs       <= 1'b0;
            r_we       <= 1'b0;
            r_oe       <= 1'b0;
            r_adrs     <= UART_ADR_STAT;
            r_wdata    <= '0;
        end else begin
            r_cs   <= 1'b0;
            r_we   <= 1'b0;
            r_oe   <= 1'b0;
            r_adrs <= UART_ADR_STAT;
            case (r_state)
                S_IDLE: begin
                    if (r_poll_cnt == POLL_LAST) begin
                        r_poll_cnt <= '0;
                        r_state    <= S_STAT;
                        r_cs       <= 1'b1;
                        r_oe       <= 1'b1;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + PW'(1);
                    end
                end
                S_STAT: begin
                    r_st_q  <= u_rdata[1:0];
                    r_state <= S_DEC;
                end
                S_DEC: begin
                    if (w_rd_sel) begin
                        r_state <= S_RD;
                        r_cs    <= 1'b1;
                        r_oe    <= 1'b1;
                        r_adrs  <= UART_ADR_DATA;
                    end else if (w_wr_sel) begin
                        r_state <= S_WR;
                        r_cs    <= 1'b1;
                        r_we    <= 1'b1;
                        r_adrs  <= UART_ADR_DATA;
                        r_wdata <= w_tx_head;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD: begin
                    r_rr    <= 1'b1;
                    r_state <= S_STAT;
                    r_cs    <= 1'b1;
                    r_oe    <= 1'b1;
                end
                S_WR: begin
                    r_rr    <= 1'b0;
                    r_state <= S_STAT;
                    r_cs    <= 1'b1;
                    r_oe    <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign u_cs    = r_cs;
    assign u_we    = r_we;
    assign u_oe    = r_oe;
    assign u_adrs  = r_adrs;
    assign u_wdata = r_wdata;

`ifdef UART_OVR_CNT_EN
    logic [7:0] r_ovr_cnt;

    // Count each decision that saw RXRDY but had no room in the RX FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovr_cnt <= '0;
        end else if ((r_state == S_DEC) && r_st_q[ST_RXRDY] && w_rx_full) begin
            r_ovr_cnt <= sat_inc8(r_ovr_cnt);
        end
    end

    assign ovr_cnt = r_ovr_cnt;
`else
    assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_lb_sequencer.sv
// Directed bench for uart_lb_sequencer with a small UART register model.
module tb_uart_lb_sequencer;

    localparam int K_WR = 1;
    localparam int K_RD = 2;
    localparam int K_ST = 3;

    logic       clk;
    logic       reset;
    logic       tx_wr;
    logic [7:0] tx_din;
    logic       tx_full;
    logic       rx_rd;
    logic [7:0] rx_dout;
    logic       rx_empty;
    logic       u_cs;
    logic       u_we;
    logic       u_oe;
    logic       u_adrs;
    logic [7:0] u_wdata;
    logic [7:0] u_rdata;
    logic [7:0] ovr_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic       txrdy = 1'b0;
    logic [7:0] rx_mem [0:15];
    int         rx_idx = 0;
    int         rx_n   = 0;

    int         ev_kind [0:63];
    logic [7:0] ev_data [0:63];
    int         ev_cyc  [0:63];
    int         ev_n = 0;

    uart_lb_sequencer #(.FIFO_DEPTH(4), .POLL_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_wr    (tx_wr),
        .tx_din   (tx_din),
        .tx_full  (tx_full),
        .rx_rd    (rx_rd),
        .rx_dout  (rx_dout),
        .rx_empty (rx_empty),
        .u_cs     (u_cs),
        .u_we     (u_we),
        .u_oe     (u_oe),
        .u_adrs   (u_adrs),
        .u_wdata  (u_wdata),
        .u_rdata  (u_rdata),
        .ovr_cnt  (ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: status reflects txrdy and pending RX bytes; a data read consumes one byte.
    assign u_rdata = u_adrs ? {6'b0, (rx_idx < rx_n), txrdy} : rx_mem[rx_idx[3:0]];

    always @(posedge clk) begin
        if (reset && u_cs && u_oe && !u_adrs) rx_idx <= rx_idx + 1;
    end

    task automatic log_ev(input int kind, input logic [7:0] d);
        if (ev_n < 64) begin
            ev_kind[ev_n] = kind;
            ev_data[ev_n] = d;
            ev_cyc[ev_n]  = cyc;
            ev_n = ev_n + 1;
        end
    endtask

    // Bus monitor: records transfers and checks strobe legality.
    always @(negedge clk) begin
        if (reset) begin
            if (u_we || u_oe) begin
                n_cmp++;
                assert (u_cs && !(u_we && u_oe)) else begin
                    n_err++;
                    $error("FAIL bus_strobe: observed cs=%0b we=%0b oe=%0b expected cs=1 and single strobe", u_cs, u_we, u_oe);
                end
            end
            if (u_cs && u_we)                 log_ev(K_WR, u_wdata);
            else if (u_cs && u_oe && !u_adrs) log_ev(K_RD, u_rdata);
            else if (u_cs && u_oe && u_adrs)  log_ev(K_ST, u_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // kind 0 selects any data transfer (RD or WR).
    function automatic bit kind_match(input int k, input int kind);
        return (kind == 0) ? (k != K_ST) : (k == kind);
    endfunction

    function automatic int cnt_kind(input int kind);
        int c = 0;
        for (int i = 0; i < ev_n; i++) if (kind_match(ev_kind[i], kind)) c++;
        return c;
    endfunction

    function automatic int find_ev(input int kind, input int nth);
        int c = 0;
        for (int i = 0; i < ev_n; i++) begin
            if (kind_match(ev_kind[i], kind)) begin
                if (c == nth) return i;
                c++;
            end
        end
        return 0;
    endfunction

    task automatic wait_kind(input int kind, input int n, input int budget, input string tag);
        int k = 0;
        while (cnt_kind(kind) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, cnt_kind(kind), n);
    endtask

    task automatic push(input logic [7:0] b);
        tx_din = b;
        tx_wr  = 1'b1;
        @(negedge clk);
        tx_wr  = 1'b0;
    endtask

    task automatic pop;
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    int i0;
    int i1;
    int k;
    int exp_ovr;
    int rd4;

    initial begin
        // 1: reset with tx_wr asserted
        reset  = 1'b0;
        tx_wr  = 1'b1;
        tx_din = 8'h77;
        rx_rd  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_cs", u_cs, 0);
        chk("rst_we", u_we, 0);
        chk("rst_oe", u_oe, 0);
        chk("rst_adrs", u_adrs, 1);
        chk("rst_ovr", ovr_cnt, 0);
        reset = 1'b1;
        tx_wr = 1'b0;
        repeat (10) @(negedge clk);

        // 2: two TX bytes, back to back
        ev_n = 0;
        push(8'h41);
        push(8'h42);
        txrdy = 1'b1;
        wait_kind(K_WR, 2, 40, "tx_two_writes");
        i0 = find_ev(K_WR, 0);
        i1 = find_ev(K_WR, 1);
        chk("tx_byte0", ev_data[i0], 8'h41);
        chk("tx_byte1", ev_data[i1], 8'h42);
        chk("tx_spacing", ev_cyc[i1] - ev_cyc[i0], 3);
        repeat (20) @(negedge clk);
        chk("tx_no_extra", cnt_kind(K_WR), 2);
        chk("tx_full_after", tx_full, 0);
        chk("tx_bus_idle", u_cs & ~u_oe, 0);
        txrdy = 1'b0;

        // 3: single RX byte
        ev_n = 0;
        rx_mem[0] = 8'h5A;
        rx_n = 1;
        k = 0;
        while (rx_empty && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("rx_arrived", rx_empty, 0);
        chk("rx_dout", rx_dout, 8'h5A);
        chk("rx_one_read", cnt_kind(K_RD), 1);
        pop();
        chk("rx_popped", rx_empty, 1);

        // 4: arbitration with both directions pending, rr cleared by reset
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ev_n = 0;
        push(8'h10);
        push(8'h11);
        rx_mem[1] = 8'hA0;
        rx_mem[2] = 8'hA1;
        txrdy = 1'b1;
        rx_n  = 3;
        wait_kind(0, 4, 60, "arb_four_xfers");
        chk("arb_k0", ev_kind[find_ev(0, 0)], K_RD);
        chk("arb_k1", ev_kind[find_ev(0, 1)], K_WR);
        chk("arb_k2", ev_kind[find_ev(0, 2)], K_RD);
        chk("arb_k3", ev_kind[find_ev(0, 3)], K_WR);
        chk("arb_d0", ev_data[find_ev(0, 0)], 8'hA0);
        chk("arb_d1", ev_data[find_ev(0, 1)], 8'h10);
        chk("arb_d2", ev_data[find_ev(0, 2)], 8'hA1);
        chk("arb_d3", ev_data[find_ev(0, 3)], 8'h11);
        chk("arb_spacing", ev_cyc[find_ev(0, 1)] - ev_cyc[find_ev(0, 0)], 3);
        txrdy = 1'b0;
        chk("arb_rx0", rx_dout, 8'hA0);
        pop();
        chk("arb_rx1", rx_dout, 8'hA1);
        pop();
        chk("arb_rx_empty", rx_empty, 1);

        // 5a: TX full and wrap
        ev_n = 0;
        push(8'h20);
        push(8'h21);
        push(8'h22);
        push(8'h23);
        push(8'h24);
        chk("full_tx_full", tx_full, 1);
        txrdy = 1'b1;
        wait_kind(K_WR, 4, 60, "full_four_writes");
        chk("full_d0", ev_data[find_ev(K_WR, 0)], 8'h20);
        chk("full_d1", ev_data[find_ev(K_WR, 1)], 8'h21);
        chk("full_d2", ev_data[find_ev(K_WR, 2)], 8'h22);
        chk("full_d3", ev_data[find_ev(K_WR, 3)], 8'h23);
        repeat (15) @(negedge clk);
        chk("full_fifth_dropped", cnt_kind(K_WR), 4);
        chk("full_tx_full_clr", tx_full, 0);
        txrdy = 1'b0;

        // 5b: RX full, six bytes offered, host not reading
        ev_n = 0;
        for (int i = 0; i < 6; i++) rx_mem[3 + i] = 8'h30 + 8'(i);
        rx_n = 9;
        wait_kind(K_RD, 4, 60, "rxfull_four_reads");
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 rx_n = rx_idx;
        repeat (12) @(negedge clk);
        chk("rxfull_reads", cnt_kind(K_RD), 4);
        rd4 = find_ev(K_RD, 3);
        exp_ovr = 0;
        for (int i = rd4 + 1; i < ev_n; i++)
            if (ev_kind[i] == K_ST && ev_data[i][1]) exp_ovr++;
`ifdef UART_OVR_CNT_EN
        chk("rxfull_ovr", ovr_cnt, exp_ovr);
`else
        chk("rxfull_ovr", ovr_cnt, 0);
`endif
        chk("rxfull_d0", rx_dout, 8'h30);
        pop();
        chk("rxfull_d1", rx_dout, 8'h31);
        pop();
        chk("rxfull_d2", rx_dout, 8'h32);
        pop();
        chk("rxfull_d3", rx_dout, 8'h33);
        pop();
        chk("rxfull_empty", rx_empty, 1);

        // 6: reset during the write cycle
        push(8'h55);
        push(8'h66);
        txrdy = 1'b1;
        k = 0;
        while (!u_we && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("midwr_saw_we", u_we, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("midwr_we", u_we, 0);
        chk("midwr_cs", u_cs, 0);
        chk("midwr_adrs", u_adrs, 1);
        chk("midwr_ovr", ovr_cnt, 0);
        reset = 1'b1;
        ev_n = 0;
        repeat (30) @(negedge clk);
        chk("midwr_tx_flushed", cnt_kind(K_WR), 0);
        chk("midwr_tx_full", tx_full, 0);
        txrdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
